// File: rtl/spb_pkg.sv
// Shared SPB responder definitions: register offsets, CTRL bits, handshake states, strobe merge.
// The strobe merge is used by every SPB responder that supports byte-granular writes.
package spb_pkg;

  localparam logic [7:0] OFS_MTIME_LO    = 8'h00;
  localparam logic [7:0] OFS_MTIME_HI    = 8'h04;
  localparam logic [7:0] OFS_MTIMECMP_LO = 8'h08;
  localparam logic [7:0] OFS_MTIMECMP_HI = 8'h0C;
  localparam logic [7:0] OFS_CTRL        = 8'h10;
  localparam logic [7:0] OFS_PRESCALE    = 8'h14;
  localparam logic [7:0] OFS_END         = 8'h18;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } spb_state_e;

  // Control bundle from the register file into the timer core.
  typedef struct packed {
    logic        en;
    logic        ie;
    logic [31:0] prescale;
    logic        pcnt_clr;
    logic        mtime_ld;
    logic [63:0] mtime_val;
    logic        cmp_ld;
    logic [63:0] cmp_val;
  } tmr_ctl_t;

  function automatic logic [31:0] wstb_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/spb_timer_core.sv
// Prescaled 64-bit mtime, mtimecmp and registered level IRQ; a load beats the increment in its cycle.
// IRQ follows its compare inputs one cycle later; no backpressure, loads are single-cycle strobes.
module spb_timer_core
  import spb_pkg::*;
#(
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  tmr_ctl_t    ctl_dat,
  output logic [63:0] mtime_dat,
  output logic [63:0] mtimecmp_dat,
  output logic        irq
);

  logic [31:0] pcnt_q, pcnt_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        irq_q, irq_d;
  logic        tick;

  always_comb begin
    tick    = ctl_dat.en && (pcnt_q == ctl_dat.prescale);
    pcnt_d  = pcnt_q;
    mtime_d = mtime_q;
    if (ctl_dat.en) begin
      pcnt_d = tick ? 32'd0 : pcnt_q + 32'd1;
    end
    if (ctl_dat.pcnt_clr) begin
      pcnt_d = 32'd0;
    end
    if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    // Software load replaces the full 64-bit value, dropping this cycle's tick and carry.
    if (ctl_dat.mtime_ld) begin
      mtime_d = ctl_dat.mtime_val;
    end
    cmp_d = ctl_dat.cmp_ld ? ctl_dat.cmp_val : cmp_q;
    irq_d = ctl_dat.ie && (mtime_q >= cmp_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q  <= 32'd0;
      mtime_q <= 64'd0;
      cmp_q   <= CMP_RST;
      irq_q   <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      irq_q   <= irq_d;
    end
  end

  assign mtime_dat    = mtime_q;
  assign mtimecmp_dat = mtimecmp_q_alias();
  assign irq          = irq_q;

  function automatic logic [63:0] mtimecmp_q_alias();
    return cmp_q;
  endfunction

endmodule

// File: rtl/spb_timer.sv
// SPB responder for the machine timer: decode, register file, MTIME_HI snapshot and handshake FSM.
// READY one cycle after VALID is sampled in IDLE, then one RESP cycle; peak one access per two cycles.
module spb_timer
  import spb_pkg::*;
#(
  parameter logic [63:0] CMP_RST      = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic [31:0] PRESCALE_RST = 32'd0
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        S_SPB_READY,
  input  logic        S_SPB_VALID,
  input  logic [3:0]  S_SPB_WSTB,
  input  logic [31:0] S_SPB_ADDR,
  input  logic [31:0] S_SPB_WDATA,
  output logic [31:0] S_SPB_RDATA,
  output logic        S_SPB_EXCPT,
  output logic        TIMER_IRQ
);

  spb_state_e  state_q, state_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        excpt_q, excpt_d;
  logic [31:0] snap_q, snap_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [31:0] presc_q, presc_d;

  tmr_ctl_t    ctl;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [7:0]  ofs;
  logic        addr_err;
  logic        is_wr;
  logic [31:0] rd_val;
  logic        addr_unused;

  assign ofs         = S_SPB_ADDR[7:0];
  assign addr_unused = ^S_SPB_ADDR[31:8];
  assign addr_err    = (ofs[1:0] != 2'b00) || (ofs >= OFS_END);
  assign is_wr       = (S_SPB_WSTB != 4'b0000);

  always_comb begin
    rd_val = 32'd0;
    case (ofs)
      OFS_MTIME_LO:    rd_val = mtime[31:0];
      OFS_MTIME_HI:    rd_val = snap_q;
      OFS_MTIMECMP_LO: rd_val = mtimecmp[31:0];
      OFS_MTIMECMP_HI: rd_val = mtimecmp[63:32];
      OFS_CTRL:        rd_val = {30'd0, ctrl_q};
      OFS_PRESCALE:    rd_val = presc_q;
      default:         rd_val = 32'd0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    ready_d       = 1'b0;
    rdata_d       = 32'd0;
    excpt_d       = 1'b0;
    snap_d        = snap_q;
    ctrl_d        = ctrl_q;
    presc_d       = presc_q;
    ctl           = '0;
    ctl.en        = ctrl_q[CTRL_EN];
    ctl.ie        = ctrl_q[CTRL_IE];
    ctl.prescale  = presc_q;
    ctl.mtime_val = mtime;
    ctl.cmp_val   = mtimecmp;

    case (state_q)
      ST_IDLE: begin
        if (S_SPB_VALID) begin
          state_d = ST_RESP;
          ready_d = 1'b1;
          if (addr_err) begin
            excpt_d = 1'b1;
          end else begin
            rdata_d = rd_val;
            // Reading the low word freezes the high word so a LO/HI pair is never torn.
            if (!is_wr && ofs == OFS_MTIME_LO) begin
              snap_d = mtime[63:32];
            end
            if (is_wr) begin
              case (ofs)
                OFS_MTIME_LO: begin
                  ctl.mtime_ld  = 1'b1;
                  ctl.mtime_val = {mtime[63:32], wstb_merge(mtime[31:0], S_SPB_WDATA, S_SPB_WSTB)};
                end
                OFS_MTIME_HI: begin
                  ctl.mtime_ld  = 1'b1;
                  ctl.mtime_val = {wstb_merge(mtime[63:32], S_SPB_WDATA, S_SPB_WSTB), mtime[31:0]};
                end
                OFS_MTIMECMP_LO: begin
                  ctl.cmp_ld  = 1'b1;
                  ctl.cmp_val = {mtimecmp[63:32], wstb_merge(mtimecmp[31:0], S_SPB_WDATA, S_SPB_WSTB)};
                end
                OFS_MTIMECMP_HI: begin
                  ctl.cmp_ld  = 1'b1;
                  ctl.cmp_val = {wstb_merge(mtimecmp[63:32], S_SPB_WDATA, S_SPB_WSTB), mtimecmp[31:0]};
                end
                OFS_CTRL: begin
                  if (S_SPB_WSTB[0]) ctrl_d = S_SPB_WDATA[1:0];
                  ctl.pcnt_clr = 1'b1;
                end
                OFS_PRESCALE: begin
                  presc_d      = wstb_merge(presc_q, S_SPB_WDATA, S_SPB_WSTB);
                  ctl.pcnt_clr = 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
      excpt_q <= 1'b0;
      snap_q  <= 32'd0;
      ctrl_q  <= 2'b00;
      presc_q <= PRESCALE_RST;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      excpt_q <= excpt_d;
      snap_q  <= snap_d;
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
    end
  end

  spb_timer_core #(
    .CMP_RST(CMP_RST)
  ) u_core (
    .clk         (CLK),
    .rst_n       (RST_N),
    .ctl_dat     (ctl),
    .mtime_dat   (mtime),
    .mtimecmp_dat(mtimecmp),
    .irq         (TIMER_IRQ)
  );

  assign S_SPB_READY = ready_q;
  assign S_SPB_RDATA = rdata_q;
  assign S_SPB_EXCPT = excpt_q;

endmodule

// File: tb/tb_spb_timer.sv
// Bench for spb_timer: directed register-map scenarios plus random SPB traffic against a behavioural model.
module tb_spb_timer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        S_SPB_READY;
  logic        S_SPB_VALID;
  logic [3:0]  S_SPB_WSTB;
  logic [31:0] S_SPB_ADDR;
  logic [31:0] S_SPB_WDATA;
  logic [31:0] S_SPB_RDATA;
  logic        S_SPB_EXCPT;
  logic        TIMER_IRQ;

  int tests_run    = 0;
  int tests_failed = 0;
  bit chk_on       = 1'b0;

  always #5 CLK = ~CLK;

  spb_timer dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .S_SPB_READY(S_SPB_READY),
    .S_SPB_VALID(S_SPB_VALID),
    .S_SPB_WSTB (S_SPB_WSTB),
    .S_SPB_ADDR (S_SPB_ADDR),
    .S_SPB_WDATA(S_SPB_WDATA),
    .S_SPB_RDATA(S_SPB_RDATA),
    .S_SPB_EXCPT(S_SPB_EXCPT),
    .TIMER_IRQ  (TIMER_IRQ)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural state plus the response the bus should show next cycle.
  typedef struct packed {
    logic [63:0] mtime;
    logic [63:0] cmp;
    logic [31:0] presc;
    logic [31:0] pcnt;
    logic [31:0] snap;
    logic [31:0] rdata;
    logic        en;
    logic        ie;
    logic        irq;
    logic        busy;
    logic        rdy;
    logic        excpt;
    logic        chk_rd;
  } model_t;

  model_t m;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic model_t model_reset();
    model_t n;
    n        = '0;
    n.cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    n.chk_rd = 1'b1;
    return n;
  endfunction

  function automatic model_t model_step(input model_t s, input logic vld, input logic [31:0] addr,
                                        input logic [3:0] wstb, input logic [31:0] wdata);
    model_t      n;
    logic [7:0]  o;
    logic        err;
    logic [31:0] rv;
    logic [31:0] cv;
    n  = s;
    o  = addr[7:0];
    rv = 32'd0;
    if (s.en) begin
      if (s.pcnt == s.presc) begin
        n.pcnt  = 32'd0;
        n.mtime = s.mtime + 64'd1;
      end else begin
        n.pcnt = s.pcnt + 32'd1;
      end
    end
    n.irq    = s.ie && (s.mtime >= s.cmp);
    n.busy   = 1'b0;
    n.rdy    = 1'b0;
    n.rdata  = 32'd0;
    n.excpt  = 1'b0;
    n.chk_rd = 1'b1;
    if (!s.busy && vld) begin
      n.busy   = 1'b1;
      n.rdy    = 1'b1;
      err      = (o[1:0] != 2'b00) || (o >= 8'h18);
      n.excpt  = err;
      n.chk_rd = err || (wstb == 4'h0);
      if (!err) begin
        case (o)
          8'h00:   rv = s.mtime[31:0];
          8'h04:   rv = s.snap;
          8'h08:   rv = s.cmp[31:0];
          8'h0C:   rv = s.cmp[63:32];
          8'h10:   rv = {30'd0, s.ie, s.en};
          default: rv = s.presc;
        endcase
        if (wstb == 4'h0) begin
          n.rdata = rv;
          if (o == 8'h00) n.snap = s.mtime[63:32];
        end else begin
          case (o)
            8'h00: n.mtime = {s.mtime[63:32], merge_bytes(s.mtime[31:0], wdata, wstb)};
            8'h04: n.mtime = {merge_bytes(s.mtime[63:32], wdata, wstb), s.mtime[31:0]};
            8'h08: n.cmp[31:0]  = merge_bytes(s.cmp[31:0], wdata, wstb);
            8'h0C: n.cmp[63:32] = merge_bytes(s.cmp[63:32], wdata, wstb);
            8'h10: begin
              cv     = merge_bytes({30'd0, s.ie, s.en}, wdata, wstb);
              n.en   = cv[0];
              n.ie   = cv[1];
              n.pcnt = 32'd0;
            end
            default: begin
              n.presc = merge_bytes(s.presc, wdata, wstb);
              n.pcnt  = 32'd0;
            end
          endcase
        end
      end
    end
    return n;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) m <= model_reset();
    else        m <= model_step(m, S_SPB_VALID, S_SPB_ADDR, S_SPB_WSTB, S_SPB_WDATA);
  end

  always @(negedge CLK) begin
    if (RST_N && chk_on) begin
      check_val("ready", S_SPB_READY, m.rdy);
      check_val("irq", TIMER_IRQ, m.irq);
      check_val("excpt", S_SPB_EXCPT, m.excpt);
      if (m.chk_rd) check_val("rdata", S_SPB_RDATA, m.rdata);
    end
  end

  // Called just after a falling edge; returns at the falling edge where READY is seen.
  task automatic spb_access(input logic [31:0] addr, input logic [3:0] wstb, input logic [31:0] wdata,
                            input bit hold, output logic [31:0] rdata, output logic excpt,
                            output int lat);
    S_SPB_VALID = 1'b1;
    S_SPB_ADDR  = addr;
    S_SPB_WSTB  = wstb;
    S_SPB_WDATA = wdata;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!S_SPB_READY && lat < 8);
    if (!S_SPB_READY) check_val("ready_timeout", S_SPB_READY, 1'b1);
    rdata = S_SPB_RDATA;
    excpt = S_SPB_EXCPT;
    if (!hold) S_SPB_VALID = 1'b0;
  endtask

  task automatic spb_wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic        e;
    int          l;
    spb_access(addr, 4'hF, data, 1'b0, d, e, l);
  endtask

  task automatic spb_rd(input logic [31:0] addr, output logic [31:0] data, output logic excpt);
    int l;
    spb_access(addr, 4'h0, 32'd0, 1'b0, data, excpt, l);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] hi;
    logic        e;
    int          lat;
    int          k;
    logic [63:0] both;

    RST_N       = 1'b0;
    S_SPB_VALID = 1'b0;
    S_SPB_WSTB  = 4'h0;
    S_SPB_ADDR  = 32'd0;
    S_SPB_WDATA = 32'd0;
    repeat (3) @(negedge CLK);
    check_val("rst_ready", S_SPB_READY, 1'b0);
    check_val("rst_rdata", S_SPB_RDATA, 32'd0);
    check_val("rst_excpt", S_SPB_EXCPT, 1'b0);
    check_val("rst_irq", TIMER_IRQ, 1'b0);
    #1 RST_N = 1'b1;
    chk_on = 1'b1;
    @(negedge CLK);

    // First read after reset: one-cycle latency, CTRL reads zero.
    spb_access(32'h10, 4'h0, 32'd0, 1'b0, d, e, lat);
    check_val("rd_lat", lat, 1);
    check_val("ctrl_rst", d, 32'd0);
    check_val("ctrl_rst_excpt", e, 1'b0);
    check_val("ctrl_rst_irq", TIMER_IRQ, 1'b0);

    // Prescale by 4 for 40 cycles.
    spb_wr(32'h14, 32'd3);
    spb_wr(32'h10, 32'd1);
    repeat (40) @(negedge CLK);
    spb_rd(32'h00, d, e);
    check_val("presc_count", (d >= 32'd9 && d <= 32'd11), 1'b1);
    spb_rd(32'h04, d, e);
    check_val("presc_hi", d, 32'd0);

    // LO/HI read pair across a 32-bit carry.
    spb_wr(32'h14, 32'd0);
    spb_wr(32'h04, 32'd0);
    spb_wr(32'h00, 32'hFFFF_FFFE);
    spb_rd(32'h00, d, e);
    spb_rd(32'h04, hi, e);
    both = {hi, d};
    check_val("carry_snapshot", (both > 64'hFFFF_FFFE && both <= 64'h1_0000_0002), 1'b1);
    spb_rd(32'h04, d, e);
    check_val("live_hi_after_carry", d, 32'd0);
    spb_rd(32'h00, d, e);
    spb_rd(32'h04, hi, e);
    check_val("snap_reload_hi", hi, 32'd1);

    // IRQ timing around mtimecmp = 5.
    spb_wr(32'h10, 32'd0);
    spb_wr(32'h00, 32'd0);
    spb_wr(32'h04, 32'd0);
    spb_wr(32'h0C, 32'd0);
    spb_wr(32'h08, 32'd5);
    spb_wr(32'h10, 32'd3);
    k = 0;
    while (!TIMER_IRQ && k < 20) begin
      @(negedge CLK);
      k++;
    end
    check_val("irq_rise_cycle", k, 6);
    spb_wr(32'h08, 32'hFFFF_FFFF);
    check_val("irq_hold", TIMER_IRQ, 1'b1);
    @(negedge CLK);
    check_val("irq_drop", TIMER_IRQ, 1'b0);

    // Decode errors leave state untouched.
    spb_rd(32'h18, d, e);
    check_val("err_rd_excpt", e, 1'b1);
    check_val("err_rd_rdata", d, 32'd0);
    spb_access(32'h02, 4'hF, 32'hFFFF_FFFF, 1'b0, d, e, lat);
    check_val("err_wr_excpt", e, 1'b1);
    check_val("err_wr_rdata", d, 32'd0);
    spb_rd(32'h10, d, e);
    check_val("err_ctrl_kept", d, 32'd3);
    spb_rd(32'h14, d, e);
    check_val("err_presc_kept", d, 32'd0);

    // Byte-lane write.
    spb_wr(32'h14, 32'h1122_3344);
    spb_access(32'h14, 4'b0010, 32'h0000_AB00, 1'b0, d, e, lat);
    spb_rd(32'h14, d, e);
    check_val("byte_merge", d, 32'h1122_AB44);

    // Reset while the response is on the bus.
    spb_wr(32'h10, 32'd1);
    #1 RST_N = 1'b0;
    #1 check_val("arst_ready", S_SPB_READY, 1'b0);
    check_val("arst_irq", TIMER_IRQ, 1'b0);
    @(negedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    spb_rd(32'h10, d, e);
    check_val("arst_ctrl", d, 32'd0);
    spb_rd(32'h14, d, e);
    check_val("arst_presc", d, 32'd0);
    spb_rd(32'h08, d, e);
    check_val("arst_cmp_lo", d, 32'hFFFF_FFFF);
    spb_rd(32'h0C, d, e);
    check_val("arst_cmp_hi", d, 32'hFFFF_FFFF);
    spb_rd(32'h00, d, e);
    check_val("arst_mtime_lo", d, 32'd0);
    spb_rd(32'h04, d, e);
    check_val("arst_mtime_hi", d, 32'd0);

    // Random traffic; the per-cycle monitor compares every response and IRQ level.
    for (int i = 0; i < 500; i++) begin
      int          sel;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  ws;
      bit          h;
      sel = $urandom_range(0, 9);
      a   = $urandom;
      if (sel == 6)      a[7:0] = 8'($urandom_range(6, 63) * 4);
      else if (sel == 7) a[7:0] = 8'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else               a[7:0] = 8'($urandom_range(0, 5) * 4);
      ws = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      wd = $urandom;
      case (a[7:0])
        8'h08:   wd = m.mtime[31:0] + 32'($urandom_range(0, 40));
        8'h0C:   wd = m.mtime[63:32];
        8'h14:   wd = 32'($urandom_range(0, 3));
        default: ;
      endcase
      h = ($urandom_range(0, 3) == 0);
      spb_access(a, ws, wd, h, d, e, lat);
      if (!h) repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    S_SPB_VALID = 1'b0;
    repeat (5) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spb_timer.md
Name: spb_timer

Overview:
SPB responder (slave endpoint) holding a RISC-V style 64-bit machine timer (mtime/mtimecmp) with a prescaler and a level interrupt.
- Connects to one master-side port of the SPB address-decode interconnect; the interconnect handles base decode.
- Answers every SPB access with a registered READY one cycle later, plus RDATA and EXCPT.
- Drives TIMER_IRQ to the core.

Parameters:
CMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp (no IRQ after reset)
PRESCALE_RST, 32'd0, reset value of PRESCALE register (0 = tick every clock)

Ports:
CLK  input  1  single clock
RST_N  input  1  asynchronous, active-low reset
S_SPB_READY  output  1  response strobe, one cycle per accepted access
S_SPB_VALID  input  1  request; master holds it plus ADDR/WSTB/WDATA until READY
S_SPB_WSTB  input  4  byte write strobes; 4'b0000 = read
S_SPB_ADDR  input  32  byte address; only ADDR[7:0] decoded
S_SPB_WDATA  input  32  write data
S_SPB_RDATA  output  32  read data, valid while READY=1
S_SPB_EXCPT  output  1  access error, valid while READY=1
TIMER_IRQ  output  1  level interrupt to the core

Behaviour:
- Register map (word offsets):
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI (reads return the snapshot register)
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 CTRL: bit0 EN, bit1 IE, others RAZ/WI
  - 0x14 PRESCALE
- Reset values: READY=0, RDATA=0, EXCPT=0, TIMER_IRQ=0, mtime=0, snapshot=0, mtimecmp=CMP_RST, CTRL=0, PRESCALE=PRESCALE_RST, prescale counter=0, FSM=IDLE.
- Handshake FSM, states IDLE and RESP:
  - IDLE & VALID -> RESP. On that edge, register RDATA and EXCPT, commit any write, and set READY<=1.
  - RESP: READY=1 for exactly one cycle. Next edge: READY<=0, RDATA<=0, EXCPT<=0, -> IDLE.
  - If VALID is still high in the cycle after RESP, it is a new access, accepted from IDLE. Peak rate is one access per 2 cycles.
  - Latency: READY is high in the cycle immediately after VALID is first sampled. The access is sampled only in IDLE.
- Error conditions: ADDR[1:0]!=0, or offset >= 0x18.
  - Response is READY=1, EXCPT=1, RDATA=0.
  - No register changes, no snapshot update.
- Writes: byte-granular per WSTB bit. Unstrobed bytes are kept.
- Reads:
  - RDATA is the register value at the accept edge.
  - Reading MTIME_LO also loads snapshot <= mtime[63:32] on the same edge.
  - Reading MTIME_HI returns the snapshot, not live mtime[63:32].
- Prescaler and counter:
  - With EN=1: if pcnt==PRESCALE then pcnt<=0 and mtime<=mtime+1; else pcnt<=pcnt+1.
  - With EN=0: pcnt and mtime hold.
  - mtime wraps from 2^64-1 to 0 silently.
  - A write to PRESCALE or CTRL clears pcnt.
- Simultaneous events: an SPB write to MTIME_LO/HI overrides the increment in that cycle for the whole 64-bit value. The unwritten half keeps its pre-increment value and no carry is applied.
- IRQ: TIMER_IRQ <= IE & (mtime >= mtimecmp), unsigned 64-bit compare, registered.
  - Level-sensitive; cleared only by writing mtimecmp above mtime or by clearing IE.
  - Updates one cycle after the compare inputs change.
- Reset mid-access: RST_N low forces IDLE and READY=0 immediately (async); the pending write is dropped. The master re-issues after reset.

Decomposition:
- Shared package spb_pkg holds:
  - register offset localparams (OFS_MTIME_LO..OFS_PRESCALE)
  - CTRL bit indices
  - FSM state encoding (ST_IDLE, ST_RESP)
  - a byte-strobe merge function, shared with other SPB responders
- One sub-module, spb_timer_core: prescaler, 64-bit mtime, compare, TIMER_IRQ.
  - Inputs: load enables and data from the top.
- Top spb_timer: SPB FSM, address decode, snapshot, register file.

Test Plan:
- Reset, then read CTRL -> READY high exactly 1 cycle after VALID, RDATA=0, EXCPT=0, TIMER_IRQ=0.
- Write PRESCALE=3, CTRL=1, wait 40 cycles, read MTIME_LO -> value 10 (±1 per spec timing); read MTIME_HI -> 0.
- Write mtime=0x0000_0000_FFFF_FFFE via HI then LO with EN=1, PRESCALE=0. Read LO then HI across the carry -> HI equals the snapshot taken at the LO read, never a torn value.
- Write MTIMECMP_HI=0, MTIMECMP_LO=5, CTRL=3 -> TIMER_IRQ rises the cycle after mtime>=5. Write MTIMECMP_LO=0xFFFF_FFFF -> IRQ drops next cycle.
- Read offset 0x18, and write ADDR=0x02 with WSTB=4'hF -> READY=1, EXCPT=1, RDATA=0; CTRL/PRESCALE unchanged.
- Byte write WSTB=4'b0010, WDATA=0x0000_AB00 to PRESCALE=0x1122_3344 -> reads 0x1122_AB44. Assert RST_N low during RESP -> READY=0 at once, registers at reset values.
